// File: rtl/ctrl_tick_pkg.sv
// Shared types and default tick timing constants for the control-tick consumers.
// The high/mid/low rate lines each have a nominal period and a matching high time.
package ctrl_tick_pkg;

  typedef enum logic [1:0] {
    SEEK,
    ACQ,
    LOCK
  } tick_state_e;

  localparam int PERIOD_HI    = 100;
  localparam int HIGH_NOM_HI  = 51;
  localparam int PERIOD_MID   = 1000;
  localparam int HIGH_NOM_MID = 501;
  localparam int PERIOD_LO    = 10000;
  localparam int HIGH_NOM_LO  = 5001;

  // First counter value at which a missing rise is declared a timeout.
  function automatic int timeout_count(input int period, input int tol);
    return period + tol + 1;
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Registers a clk-synchronous tick line and flags its rising and falling edges.
// Reusable by any block that consumes the control tick square waves.
module tick_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic rise,
  output logic fall
);

  logic tick_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_d <= 1'b0;
    else     tick_d <= tick_in;
  end

  assign rise = tick_in & ~tick_d;
  assign fall = ~tick_in & tick_d;

endmodule

// File: rtl/control_tick_monitor.sv
// Checks one control tick line: measures period and high time, strobes each rise,
// locks after LOCK_N good periods and keeps sticky period/duty/timeout faults.
module control_tick_monitor
  import ctrl_tick_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int PERIOD   = PERIOD_LO,
  parameter int HIGH_NOM = HIGH_NOM_LO,
  parameter int TOL      = 4,
  parameter int LOCK_N   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             clr_fault,
  output logic             tick_rise,
  output logic             locked,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] high_meas,
  output logic             fault_period,
  output logic             fault_duty,
  output logic             fault_timeout,
  output logic [7:0]       err_cnt
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(timeout_count(PERIOD, TOL));
  localparam logic signed [CNT_W:0] PERIOD_S = (CNT_W+1)'(PERIOD);
  localparam logic signed [CNT_W:0] HIGH_S   = (CNT_W+1)'(HIGH_NOM);
  localparam logic signed [CNT_W:0] TOL_S    = (CNT_W+1)'(TOL);

  if (longint'(PERIOD) + longint'(TOL) + 1 > (longint'(1) << CNT_W) - 1) begin : g_bad_params
    $error("control_tick_monitor: PERIOD+TOL+1 does not fit in CNT_W bits");
  end

  tick_state_e state, state_nxt;
  logic [GW-1:0]    good_cnt, good_nxt;
  logic             locked_nxt;
  logic [CNT_W-1:0] cnt, hcnt;
  logic             rise, fall;
  logic signed [CNT_W:0] period_diff, high_diff;
  logic period_bad, duty_bad, timeout_hit, check_now;
  logic set_period, set_duty, set_timeout, fault_evt;

  tick_edge_detect u_edge (
    .clk    (clk),
    .rst    (rst),
    .tick_in(tick_in),
    .rise   (rise),
    .fall   (fall)
  );

  // Signed differences so that short and long periods are both caught.
  assign period_diff = $signed({1'b0, cnt}) - PERIOD_S;
  assign high_diff   = $signed({1'b0, high_meas}) - HIGH_S;
  assign period_bad  = (period_diff > TOL_S) || (period_diff < -TOL_S);
  assign duty_bad    = (high_diff > TOL_S) || (high_diff < -TOL_S);
  assign timeout_hit = (cnt == TIMEOUT_CNT) && !rise;
  assign check_now   = rise && (state != SEEK);
  assign fault_evt   = set_period | set_duty | set_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEEK;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      locked   <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    good_nxt    = good_cnt;
    locked_nxt  = locked;
    set_period  = 1'b0;
    set_duty    = 1'b0;
    set_timeout = 1'b0;
    case (state)
      SEEK: begin
        if (rise) begin
          state_nxt = ACQ;
          good_nxt  = '0;
        end
      end
      ACQ: begin
        if (rise) begin
          if (period_bad || duty_bad) begin
            good_nxt   = '0;
            set_period = period_bad;
            set_duty   = duty_bad;
          end else if (good_cnt == GW'(LOCK_N - 1)) begin
            good_nxt   = GW'(LOCK_N);
            state_nxt  = LOCK;
            locked_nxt = 1'b1;
          end else begin
            good_nxt = good_cnt + 1'b1;
          end
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          locked_nxt  = 1'b0;
          state_nxt   = SEEK;
        end
      end
      LOCK: begin
        if (rise) begin
          if (period_bad || duty_bad) begin
            good_nxt   = '0;
            locked_nxt = 1'b0;
            state_nxt  = ACQ;
            set_period = period_bad;
            set_duty   = duty_bad;
          end
        end else if (timeout_hit) begin
          set_timeout = 1'b1;
          locked_nxt  = 1'b0;
          state_nxt   = SEEK;
        end
      end
      default: begin
        state_nxt  = SEEK;
        good_nxt   = '0;
        locked_nxt = 1'b0;
      end
    endcase
  end

  // A fault detected in the same cycle as clr_fault survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt           <= '0;
      hcnt          <= '0;
      tick_rise     <= 1'b0;
      period_meas   <= '0;
      high_meas     <= '0;
      fault_period  <= 1'b0;
      fault_duty    <= 1'b0;
      fault_timeout <= 1'b0;
      err_cnt       <= '0;
    end else begin
      tick_rise <= rise;
      if (rise)            cnt <= CNT_W'(1);
      else if (cnt != '1)  cnt <= cnt + 1'b1;
      if (rise)                        hcnt <= CNT_W'(1);
      else if (tick_in && hcnt != '1)  hcnt <= hcnt + 1'b1;
      if (fall)      high_meas   <= hcnt;
      if (check_now) period_meas <= cnt;
      fault_period  <= (fault_period  & ~clr_fault) | set_period;
      fault_duty    <= (fault_duty    & ~clr_fault) | set_duty;
      fault_timeout <= (fault_timeout & ~clr_fault) | set_timeout;
      if (fault_evt)
        err_cnt <= clr_fault ? 8'd1 : ((err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1);
      else if (clr_fault)
        err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_control_tick_monitor.sv
// Directed bench for control_tick_monitor at PERIOD=100, HIGH_NOM=51, TOL=2, LOCK_N=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_control_tick_monitor;

  localparam int CNT_W    = 16;
  localparam int PERIOD   = 100;
  localparam int HIGH_NOM = 51;
  localparam int TOL      = 2;
  localparam int LOCK_N   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             tick_in;
  logic             clr_fault;
  logic             tick_rise;
  logic             locked;
  logic [CNT_W-1:0] period_meas;
  logic [CNT_W-1:0] high_meas;
  logic             fault_period;
  logic             fault_duty;
  logic             fault_timeout;
  logic [7:0]       err_cnt;

  int total = 0;
  int bad = 0;
  int rise_count = 0;
  int rise_snap;
  int prev_p;
  int jit_p[4] = '{98, 102, 98, 102};
  int jit_h[4] = '{49, 53, 49, 53};

  control_tick_monitor #(
    .CNT_W   (CNT_W),
    .PERIOD  (PERIOD),
    .HIGH_NOM(HIGH_NOM),
    .TOL     (TOL),
    .LOCK_N  (LOCK_N)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_in      (tick_in),
    .clr_fault    (clr_fault),
    .tick_rise    (tick_rise),
    .locked       (locked),
    .period_meas  (period_meas),
    .high_meas    (high_meas),
    .fault_period (fault_period),
    .fault_duty   (fault_duty),
    .fault_timeout(fault_timeout),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tick_rise) rise_count <= rise_count + 1;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic hold(input logic v, input int n);
    tick_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input int p, input int h);
    hold(1'b1, h);
    hold(1'b0, p - h);
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_rise"},   tick_rise, 0);
    check_output({tag, "_locked"}, locked, 0);
    check_output({tag, "_pmeas"},  period_meas, 0);
    check_output({tag, "_hmeas"},  high_meas, 0);
    check_output({tag, "_flags"},  {fault_period, fault_duty, fault_timeout}, 0);
    check_output({tag, "_err"},    err_cnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    tick_in = 1'b0;
    clr_fault = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Nominal lock: rises 2..5 are good, lock is visible one cycle after rise 5.
    repeat (4) apply_stimulus(100, 51);
    check_output("lock_early", locked, 0);
    hold(1'b1, 1);
    check_output("lock_rise5", locked, 1);
    check_output("strobe_on", tick_rise, 1);
    hold(1'b1, 1);
    check_output("strobe_off", tick_rise, 0);
    check_output("nom_pmeas", period_meas, 100);
    check_output("nom_hmeas", high_meas, 51);
    check_output("nom_flags", {fault_period, fault_duty, fault_timeout}, 0);
    hold(1'b1, 49);
    hold(1'b0, 49);

    // Jitter inside tolerance.
    rise_snap = rise_count;
    prev_p = 100;
    for (int i = 0; i < 4; i++) begin
      hold(1'b1, 1);
      check_output("jit_pmeas", period_meas, prev_p);
      check_output("jit_locked", locked, 1);
      hold(1'b1, jit_h[i] - 1);
      hold(1'b0, jit_p[i] - jit_h[i]);
      prev_p = jit_p[i];
    end
    hold(1'b1, 1);
    check_output("jit_last_pmeas", period_meas, 102);
    check_output("jit_last_hmeas", high_meas, 53);
    check_output("jit_flags", {fault_period, fault_duty, fault_timeout}, 0);
    check_output("jit_err", err_cnt, 0);
    hold(1'b1, 50);
    hold(1'b0, 49);
    check_output("jit_rise_count", rise_count - rise_snap, 5);

    // Single short period of 97 while locked.
    hold(1'b1, 1);
    hold(1'b1, 50);
    hold(1'b0, 46);
    hold(1'b1, 1);
    check_output("short_fault", fault_period, 1);
    check_output("short_unlock", locked, 0);
    check_output("short_err", err_cnt, 1);
    check_output("short_pmeas", period_meas, 97);
    hold(1'b1, 50);
    hold(1'b0, 49);
    repeat (3) apply_stimulus(100, 51);
    check_output("relock_early", locked, 0);
    hold(1'b1, 1);
    check_output("relock", locked, 1);
    check_output("relock_sticky", fault_period, 1);
    check_output("relock_err", err_cnt, 1);
    hold(1'b1, 50);
    hold(1'b0, 49);

    // Asynchronous reset while locked, sampled between clock edges.
    #2 rst = 1'b1;
    #1 check_idle("rst_async");
    @(negedge clk);
    rst = 1'b0;

    // High time 60: every checked rise is a duty fault.
    for (int k = 1; k <= 6; k++) begin
      apply_stimulus(100, 60);
      check_output("duty_err", err_cnt, k - 1);
      check_output("duty_locked", locked, 0);
    end
    check_output("duty_flag", fault_duty, 1);
    check_output("duty_pflag", fault_period, 0);
    check_output("duty_hmeas", high_meas, 60);

    // Re-lock: first rise still sees the 60-cycle high time.
    repeat (5) apply_stimulus(100, 51);
    check_output("pre_to_locked", locked, 1);
    check_output("pre_to_err", err_cnt, 6);

    // Stuck low: cnt is 100 here; timeout lands on the edge where cnt is 103.
    repeat (3) @(negedge clk);
    check_output("to_not_yet", fault_timeout, 0);
    check_output("to_still_locked", locked, 1);
    @(negedge clk);
    check_output("to_flag", fault_timeout, 1);
    check_output("to_unlock", locked, 0);
    check_output("to_err", err_cnt, 7);
    hold(1'b0, 10);
    hold(1'b1, 1);
    check_output("seek_strobe", tick_rise, 1);
    check_output("seek_err", err_cnt, 7);
    check_output("seek_pflag", fault_period, 0);
    check_output("seek_pmeas", period_meas, 100);
    hold(1'b1, 50);
    hold(1'b0, 49);

    // clr_fault coincident with a 90-cycle period, then clr_fault alone.
    hold(1'b1, 1);
    hold(1'b1, 50);
    hold(1'b0, 39);
    clr_fault = 1'b1;
    hold(1'b1, 1);
    clr_fault = 1'b0;
    check_output("clrset_pflag", fault_period, 1);
    check_output("clrset_err", err_cnt, 1);
    check_output("clrset_others", {fault_duty, fault_timeout}, 0);
    check_output("clrset_pmeas", period_meas, 90);
    hold(1'b1, 50);
    hold(1'b0, 20);
    clr_fault = 1'b1;
    hold(1'b0, 1);
    clr_fault = 1'b0;
    check_output("clr_flags", {fault_period, fault_duty, fault_timeout}, 0);
    check_output("clr_err", err_cnt, 0);
    hold(1'b0, 28);

    // Period 50 / high 25: both faults per check, one count each, saturating.
    for (int i = 0; i < 258; i++) begin
      hold(1'b1, 1);
      if (i == 0) check_output("sat_first_good", err_cnt, 0);
      if (i == 1) begin
        check_output("dual_err", err_cnt, 1);
        check_output("dual_flags", {fault_period, fault_duty}, 2'b11);
      end
      if (i == 2) check_output("dual_err2", err_cnt, 2);
      if (i == 254) check_output("sat_254", err_cnt, 254);
      if (i == 257) check_output("sat_hold", err_cnt, 255);
      hold(1'b1, 24);
      hold(1'b0, 25);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
